vezerles_letapogato: RTL and testbench

//  Scanning initiator for the three-input control block (inputs a,b,c -> outputs q1,q2).
//  - Drives every input combination 0..2^N_IN-1 onto abc_out.
//  - Waits a settle time, samples {q2,q1} and packs all responses into one result word.
//  - Sits in the bench/board wrapper next to the control block; lets the whole truth table
//    be read back with a single start pulse.

---
 rtl/vezerles_pkg.sv | 21 ++
 rtl/vezerles_settle_cnt.sv | 30 +++
 rtl/vezerles_letapogato.sv | 141 ++++++++++++++
 tb/tb_vezerles_letapogato.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vezerles_pkg.sv
// Shared types and defaults for the control-block truth-table scanner.
package vezerles_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_e;

  localparam int          N_IN_DEF       = 3;
  localparam int          SETTLE_CYC_DEF = 2;
  localparam logic [15:0] TRUTH_TABLE    = 16'hFA95;
  localparam logic [15:0] GOLDEN_DEF     = TRUTH_TABLE;

  // Settle counter width; never narrower than one bit, even with no settle time.
  function automatic int cntWidth(input int settle);
    return (settle < 1) ? 1 : $clog2(settle + 1);
  endfunction

endpackage

// File: rtl/vezerles_settle_cnt.sv
// Loadable down-counter that times the settle interval after each vector.
module vezerles_settle_cnt #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (dec_i && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/vezerles_letapogato.sv
// Scans every input combination of the control block and packs {q2,q1} per vector.
// Optional VEZERLES_CHECK_EN adds a registered mismatch flag against GOLDEN.
module vezerles_letapogato
  import vezerles_pkg::*;
#(
  parameter int                      N_IN       = N_IN_DEF,
  parameter int                      SETTLE_CYC = SETTLE_CYC_DEF,
  parameter logic [2*(2**N_IN)-1:0] GOLDEN     = GOLDEN_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [N_IN-1:0]          abc_out,
  input  logic                     q1_in,
  input  logic                     q2_in,
  output logic [2*(2**N_IN)-1:0]   result,
  output logic                     result_valid
`ifdef VEZERLES_CHECK_EN
  ,
  output logic                     mismatch
`endif
);

  localparam int NV = 2**N_IN;
  localparam int RW = 2*NV;
  localparam int CW = cntWidth(SETTLE_CYC);
  localparam int IW = N_IN + 1;
  localparam logic [CW-1:0] SETTLE_LOAD = (SETTLE_CYC == 0) ? '0 : CW'(SETTLE_CYC - 1);
  localparam logic [IW-1:0] LAST_IDX    = IW'(NV - 1);
  localparam state_e        AFTER_VEC   = (SETTLE_CYC == 0) ? SAMPLE : SETTLE;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [N_IN-1:0] abc_q, abc_d;
  logic [RW-1:0]   res_q, res_d;
  logic            rv_q, rv_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            mism_q, mism_d;
  logic            cntLoad, cntDec, cntZero;

  vezerles_settle_cnt #(.W(CW)) u_settle (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cntLoad),
    .load_val_i (SETTLE_LOAD),
    .dec_i      (cntDec),
    .zero_o     (cntZero)
  );

  // done, result_valid and busy change on the edge that leaves DONE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    abc_d   = abc_q;
    res_d   = res_q;
    rv_d    = rv_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    mism_d  = mism_q;
    cntLoad = 1'b0;
    cntDec  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d  = 1'b1;
          idx_d   = '0;
          abc_d   = '0;
          res_d   = '0;
          rv_d    = 1'b0;
          mism_d  = 1'b0;
          cntLoad = 1'b1;
          state_d = AFTER_VEC;
        end
      end
      SETTLE: begin
        if (cntZero) state_d = SAMPLE;
        else         cntDec  = 1'b1;
      end
      SAMPLE: begin
        res_d[{idx_q[N_IN-1:0], 1'b0} +: 2] = {q2_in, q1_in};
        if (idx_q != LAST_IDX) begin
          idx_d   = idx_q + 1'b1;
          abc_d   = abc_q + 1'b1;
          cntLoad = 1'b1;
          state_d = AFTER_VEC;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        rv_d    = 1'b1;
        busy_d  = 1'b0;
`ifdef VEZERLES_CHECK_EN
        mism_d  = (res_q != GOLDEN);
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      abc_q   <= '0;
      res_q   <= '0;
      rv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mism_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      abc_q   <= abc_d;
      res_q   <= res_d;
      rv_q    <= rv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mism_q  <= mism_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign abc_out      = abc_q;
  assign result       = res_q;
  assign result_valid = rv_q;

`ifdef VEZERLES_CHECK_EN
  assign mismatch = mism_q;
`else
  logic unused_check;
  assign unused_check = mism_q ^ (^GOLDEN);
`endif

endmodule

// File: tb/tb_vezerles_letapogato.sv
// Bench for the truth-table scanner: slow (settle 2) and fast (settle 0) instances.
// A done-triggered monitor pops expected result and done cycle from per-instance queues.
module tb_vezerles_letapogato;

  typedef struct {
    logic [15:0] res;
    int          doneAt;
  } exp_t;

  localparam logic [15:0] GOLD = 16'hFA95;

  logic        clk = 1'b0;
  logic        rst;
  logic        start2, start0;
  logic        tieMode;
  logic        busy2, done2, rv2, busy0, done0, rv0;
  logic [2:0]  abc2, abc0;
  logic [15:0] res2, res0;
  logic        q1s2, q2s2, q1s0, q2s0;
`ifdef VEZERLES_CHECK_EN
  logic        mism2, mism0;
`endif

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   k;
  exp_t expQ2[$];
  exp_t expQ0[$];
  exp_t e2, e0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference control block: {q2,q1} for input abc, independent of the scanner.
  function automatic logic [1:0] ctrlBlock(input logic [2:0] abc);
    logic [15:0] tt;
    tt = GOLD;
    return tt[{abc, 1'b0} +: 2];
  endfunction

  assign {q2s2, q1s2} = tieMode ? 2'b10 : ctrlBlock(abc2);
  assign {q2s0, q1s0} = ctrlBlock(abc0);

  vezerles_letapogato #(.N_IN(3), .SETTLE_CYC(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start2),
    .busy         (busy2),
    .done         (done2),
    .abc_out      (abc2),
    .q1_in        (q1s2),
    .q2_in        (q2s2),
    .result       (res2),
    .result_valid (rv2)
`ifdef VEZERLES_CHECK_EN
    ,
    .mismatch     (mism2)
`endif
  );

  vezerles_letapogato #(.N_IN(3), .SETTLE_CYC(0)) dut0 (
    .clk          (clk),
    .rst          (rst),
    .start        (start0),
    .busy         (busy0),
    .done         (done0),
    .abc_out      (abc0),
    .q1_in        (q1s0),
    .q2_in        (q2s0),
    .result       (res0),
    .result_valid (rv0)
`ifdef VEZERLES_CHECK_EN
    ,
    .mismatch     (mism0)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic waitUntil(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic applyStimulus(input bit fast, input logic [15:0] expRes, output int acc);
    acc = cyc + 1;
    if (fast) begin
      start0 = 1'b1;
      expQ0.push_back('{res: expRes, doneAt: acc + 9});
    end else begin
      start2 = 1'b1;
      expQ2.push_back('{res: expRes, doneAt: acc + 25});
    end
    @(negedge clk);
    start0 = 1'b0;
    start2 = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && done2) begin
      if (expQ2.size() == 0) begin
        checkOutput("slow unexpected done", 32'd1, 32'd0);
      end else begin
        e2 = expQ2.pop_front();
        checkOutput("slow done cycle", cyc, e2.doneAt);
        checkOutput("slow result", {16'h0, res2}, {16'h0, e2.res});
        checkOutput("slow result_valid at done", {31'h0, rv2}, 32'd1);
        checkOutput("slow busy at done", {31'h0, busy2}, 32'd0);
`ifdef VEZERLES_CHECK_EN
        checkOutput("slow mismatch", {31'h0, mism2}, {31'h0, (e2.res != GOLD)});
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done0) begin
      if (expQ0.size() == 0) begin
        checkOutput("fast unexpected done", 32'd1, 32'd0);
      end else begin
        e0 = expQ0.pop_front();
        checkOutput("fast done cycle", cyc, e0.doneAt);
        checkOutput("fast result", {16'h0, res0}, {16'h0, e0.res});
        checkOutput("fast result_valid at done", {31'h0, rv0}, 32'd1);
`ifdef VEZERLES_CHECK_EN
        checkOutput("fast mismatch", {31'h0, mism0}, {31'h0, (e0.res != GOLD)});
`endif
      end
    end
  end

  initial begin
    rst = 1'b1; start2 = 1'b0; start0 = 1'b0; tieMode = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy",   {31'h0, busy2}, 32'd0);
    checkOutput("reset done",   {31'h0, done2}, 32'd0);
    checkOutput("reset abc",    {29'h0, abc2},  32'd0);
    checkOutput("reset result", {16'h0, res2},  32'd0);
    checkOutput("reset rv",     {31'h0, rv2},   32'd0);
    checkOutput("reset fast rv", {31'h0, rv0},  32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Full scan with settle time 2: vector i held over cycles k+3i..k+3i+2.
    applyStimulus(1'b0, GOLD, k);
    for (int i = 0; i < 8; i++) begin
      waitUntil(k + 3*i);
      checkOutput($sformatf("scan abc slot %0d start", i), {29'h0, abc2}, i);
      checkOutput($sformatf("scan busy slot %0d", i), {31'h0, busy2}, 32'd1);
      checkOutput($sformatf("scan rv slot %0d", i), {31'h0, rv2}, 32'd0);
      waitUntil(k + 3*i + 2);
      checkOutput($sformatf("scan abc slot %0d end", i), {29'h0, abc2}, i);
    end
    waitUntil(k + 24);
    checkOutput("scan done before k+25", {31'h0, done2}, 32'd0);
    checkOutput("scan busy in DONE", {31'h0, busy2}, 32'd1);
    waitUntil(k + 27);
    checkOutput("hold rv", {31'h0, rv2}, 32'd1);
    checkOutput("hold result", {16'h0, res2}, {16'h0, GOLD});
    checkOutput("hold abc last", {29'h0, abc2}, 32'd7);
    checkOutput("hold done pulse", {31'h0, done2}, 32'd0);

    // Extra start pulses during a scan must be ignored.
    applyStimulus(1'b0, GOLD, k);
    checkOutput("restart clears result", {16'h0, res2}, 32'd0);
    checkOutput("restart clears rv", {31'h0, rv2}, 32'd0);
    waitUntil(k + 4); start2 = 1'b1; @(negedge clk); start2 = 1'b0;
    waitUntil(k + 6);
    checkOutput("ignore start abc", {29'h0, abc2}, 32'd2);
    waitUntil(k + 9); start2 = 1'b1; @(negedge clk); start2 = 1'b0;
    waitUntil(k + 12);
    checkOutput("ignore start abc 2", {29'h0, abc2}, 32'd4);
    waitUntil(k + 30);

    // q1 tied 0, q2 tied 1.
    tieMode = 1'b1;
    applyStimulus(1'b0, 16'hAAAA, k);
    waitUntil(k + 27);
    checkOutput("tied result hold", {16'h0, res2}, 32'h0000AAAA);
    tieMode = 1'b0;

    // Asynchronous reset in the middle of a scan.
    applyStimulus(1'b0, GOLD, k);
    waitUntil(k + 12);
    checkOutput("pre-reset abc", {29'h0, abc2}, 32'd4);
    checkOutput("pre-reset busy", {31'h0, busy2}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("midreset busy",   {31'h0, busy2}, 32'd0);
    checkOutput("midreset abc",    {29'h0, abc2},  32'd0);
    checkOutput("midreset result", {16'h0, res2},  32'd0);
    checkOutput("midreset rv",     {31'h0, rv2},   32'd0);
    expQ2.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(1'b0, GOLD, k);
    waitUntil(k + 27);
    checkOutput("fresh scan rv", {31'h0, rv2}, 32'd1);

    // Zero settle time: a new vector every cycle.
    applyStimulus(1'b1, GOLD, k);
    for (int i = 0; i < 8; i++) begin
      waitUntil(k + i);
      checkOutput($sformatf("fast abc %0d", i), {29'h0, abc0}, i);
    end
    waitUntil(k + 11);
    checkOutput("fast hold result", {16'h0, res0}, {16'h0, GOLD});

    // Start held high: back-to-back scans accepted 26 cycles apart.
    k = cyc + 1;
    start2 = 1'b1;
    expQ2.push_back('{res: GOLD, doneAt: k + 25});
    expQ2.push_back('{res: GOLD, doneAt: k + 51});
    expQ2.push_back('{res: GOLD, doneAt: k + 77});
    waitUntil(k + 1);
    checkOutput("b2b rv low first", {31'h0, rv2}, 32'd0);
    waitUntil(k + 26);
    checkOutput("b2b rv low second", {31'h0, rv2}, 32'd0);
    checkOutput("b2b busy second", {31'h0, busy2}, 32'd1);
    waitUntil(k + 52);
    checkOutput("b2b rv low third", {31'h0, rv2}, 32'd0);
    waitUntil(k + 59);
    start2 = 1'b0;
    waitUntil(k + 82);
    checkOutput("b2b final rv", {31'h0, rv2}, 32'd1);
    checkOutput("b2b idle busy", {31'h0, busy2}, 32'd0);

    checkOutput("slow pending dones", expQ2.size(), 32'd0);
    checkOutput("fast pending dones", expQ0.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
